laser_rx_framed: RTL and testbench
==================================

Name: laser_rx_framed

Overview:
- Parametrised next-generation laser receiver.
- Deserialises one laser channel into DATA_BITS-wide words.
  - Frame: idle low, start bit high, data LSB first, optional parity bit, stop bit low.
- Adds over the previous receiver:
  - 3-sample majority voting per bit.
  - Even/odd parity check.
  - Framing-error detection with a stuck-high lockout.
  - Valid/ready output holding register with overrun reporting.
- Sits between the photodiode input pin and the packet/FIFO layer.

Parameters:
DATA_BITS, 8, data bits per frame (1..16)
CLKS_PER_BIT, 8, clock cycles per bit period (>=4)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
laser_in  input  1  raw asynchronous receiver input
data_out  output  DATA_BITS  received word; stable while data_valid=1
data_valid  output  1  word available; held until accepted
data_ready  input  1  consumer accepts word when data_valid && data_ready at posedge
parity_err  output  1  one-cycle pulse: frame dropped, parity mismatch
frame_err  output  1  one-cycle pulse: frame dropped, stop bit not low
overrun  output  1  one-cycle pulse: good frame dropped, holding register full
busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, all error pulses=0, busy=0.
  - FSM=IDLE; synchroniser flops=0; bit/clock counters=0.
  - Reset mid-frame aborts the frame; the held word is discarded.
- Synchroniser: laser_in passes through two flops (s1, s2). The FSM sees only s2.
- Constants:
  - M = CLKS_PER_BIT/2 (integer division).
  - P = 1 if PARITY!=0, else 0.
  - B = 1+DATA_BITS+P (index of the stop bit).
- Clock counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit, then wraps to 0 and advances to the next bit.
  - s2 is sampled at counts M-1, M and M+1.
  - Bit value = majority of the 3 samples, decided at count M+1.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE: s2=1 -> START, counter cleared to 0.
  - START: at decision, majority 0 -> IDLE (glitch rejected, no flag); majority 1 -> continue to DATA at wrap.
  - DATA: the decided bit shifts into data bit index n, LSB first. After bit DATA_BITS-1 -> PAR if P=1, else STOP.
  - PAR: the decided bit is compared against the XOR of the data bits (even), or its inverse (odd). Mismatch is recorded. -> STOP at wrap.
  - STOP, decided at count M+1, with no wait for the wrap:
    - majority 0 and no parity mismatch -> deliver; -> IDLE.
    - majority 0 and parity mismatch -> parity_err; -> IDLE.
    - majority 1 -> frame_err; -> BREAK.
  - BREAK: wait for s2=0, then -> IDLE. A stuck-high line therefore raises exactly one frame_err and does not re-trigger.
- Delivery, registered one cycle after the stop decision:
  - data_valid=0, or data_valid && data_ready in the same cycle: data_out loads the new word; data_valid=1. Simultaneous accept and load yields no overrun and no gap.
  - data_valid=1 && !data_ready: new word dropped; overrun=1 for one cycle; old word retained.
- Acceptance: data_valid && data_ready with no new word -> data_valid=0 next cycle; data_out holds its value.
- Latency: data_valid, or an error pulse, rises after posedge number B*CLKS_PER_BIT+M+4, counting the first posedge that samples laser_in=1 as posedge 0. With defaults: 80.
- Error pulses are mutually exclusive per frame; at most one pulse per frame.
- Back-to-back frames: a start bit may begin one cycle after the STOP decision. The remaining half stop-bit period is not required.

Test Plan:
- Defaults; send 0xA5 (idle 0, start 1, bits 1,0,1,0,0,1,0,1, stop 0), data_ready=1 -> data_valid=1 for exactly one cycle, 80 posedges after first high sample; data_out=0xA5; no error flags.
- 2-cycle high glitch on an idle line -> FSM returns to IDLE; data_valid, frame_err, parity_err all stay 0.
- PARITY=1; send 0x03 with parity bit 1 -> parity_err pulses once; data_valid stays 0. Resend with parity 0 -> data_out=0x03.
- laser_in held high from idle for 400 cycles -> exactly one frame_err pulse; busy=1 until the line drops; the next valid frame 0x5A is received correctly.
- data_ready=0; send 0x11 then 0x22 -> data_out=0x11, data_valid held, overrun pulses once. Then raise data_ready -> word accepted; data_valid=0.
- Assert reset at data bit 4 of a frame; release; send 0x3C -> no output from the aborted frame; data_out=0x3C afterwards.

Source files
------------

// File: rtl/laser_rx_framed_if.sv
// Output side of the laser receiver: held word with valid/ready plus status pulses.
interface laser_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun, busy,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun, busy,
    output data_ready
  );
endinterface

// File: rtl/laser_rx_framed.sv
// Framed laser receiver: 2-flop sync, 3-sample majority per bit, optional parity,
// framing check with stuck-high lockout, and a valid/ready holding register.
module laser_rx_framed #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              laser_in,
  laser_rx_framed_if.master rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = CLKS_PER_BIT / 2;
  localparam bit P_EN  = (PARITY != 0);
  localparam bit P_ODD = (PARITY == 2);
  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_next;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pmis_q, pmis_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 maj, wrap, decide, deliver;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    samp_d   = samp_q;
    shift_d  = shift_q;
    pmis_d   = pmis_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    deliver  = 1'b0;

    wrap     = (cnt_q == C_LAST);
    decide   = (cnt_q == C_DEC);
    cnt_next = wrap ? '0 : cnt_q + 1'b1;
    // Third sample is the live s2 at the decision count.
    maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_q) | (samp_q[1] & s2_q);
    if (cnt_q == C_S0) samp_d[0] = s2_q;
    if (cnt_q == C_S1) samp_d[1] = s2_q;

    if (dvalid_q && rx.data_ready) dvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s2_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          pmis_d  = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_next;
        if (decide && !maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_next;
        if (decide) shift_d[bit_q] = maj;
        if (wrap) begin
          if (bit_q == B_LAST) begin
            bit_d   = '0;
            state_d = P_EN ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        cnt_d = cnt_next;
        if (decide) pmis_d = maj ^ (^shift_q) ^ P_ODD;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = cnt_next;
        // Decide mid stop bit so a new start bit can follow immediately.
        if (decide) begin
          cnt_d = '0;
          if (maj) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else if (pmis_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (!s2_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (!dvalid_q || rx.data_ready) begin
        dout_d   = shift_q;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      samp_q   <= '0;
      shift_q  <= '0;
      pmis_q   <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= laser_in;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      shift_q  <= shift_d;
      pmis_q   <= pmis_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx.data_out   = dout_q;
  assign rx.data_valid = dvalid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;
  assign rx.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_laser_rx_framed.sv
// Directed bench for laser_rx_framed: one no-parity and one even-parity instance.
module tb_laser_rx_framed;

  localparam int CPB = 8;

  logic clock;
  logic reset;
  logic line;
  logic sel;
  logic ready;
  logic laser0, laser1;

  int n_chk = 0;
  int n_err = 0;
  int perr_cnt0 = 0, ferr_cnt0 = 0, ovr_cnt0 = 0;
  int perr_cnt1 = 0, ferr_cnt1 = 0, ovr_cnt1 = 0;
  int lat;

  laser_rx_framed_if #(.DATA_BITS(8)) if0 ();
  laser_rx_framed_if #(.DATA_BITS(8)) if1 ();

  laser_rx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .laser_in(laser0), .rx(if0)
  );
  laser_rx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .laser_in(laser1), .rx(if1)
  );

  assign laser0 = sel ? 1'b0 : line;
  assign laser1 = sel ? line : 1'b0;
  assign if0.data_ready = ready;
  assign if1.data_ready = ready;

  logic       vld, bsy;
  logic [7:0] dout;
  assign vld  = sel ? if1.data_valid : if0.data_valid;
  assign bsy  = sel ? if1.busy       : if0.busy;
  assign dout = sel ? if1.data_out   : if0.data_out;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (if0.parity_err) perr_cnt0++;
    if (if0.frame_err)  ferr_cnt0++;
    if (if0.overrun)    ovr_cnt0++;
    if (if1.parity_err) perr_cnt1++;
    if (if1.frame_err)  ferr_cnt1++;
    if (if1.overrun)    ovr_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // par < 0 sends no parity bit
  task automatic send_frame(input logic [7:0] d, input int par);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(1'b0);
  endtask

  // n = posedges from the first high sample until data_valid is seen; -1 on timeout
  task automatic wait_valid(output int n);
    n = -1;
    @(posedge clock);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (vld) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    line  = 1'b0;
    sel   = 1'b0;
    ready = 1'b1;
    idle(4);
    chk("rst_valid", 32'(if0.data_valid), 32'd0);
    chk("rst_dout",  32'(if0.data_out),   32'd0);
    chk("rst_busy",  32'(if0.busy),       32'd0);
    chk("rst_flags", 32'({if0.parity_err, if0.frame_err, if0.overrun}), 32'd0);
    reset = 1'b0;
    idle(4);

    // 0xA5, no parity: latency 9*8+4+4 = 80
    fork
      send_frame(8'hA5, -1);
      wait_valid(lat);
    join
    chk("a5_latency", 32'(lat), 32'd80);
    chk("a5_dout", 32'(dout), 32'hA5);
    idle(1);
    chk("a5_one_cycle", 32'(vld), 32'd0);
    idle(10);
    chk("a5_no_err", 32'(perr_cnt0 + ferr_cnt0 + ovr_cnt0), 32'd0);

    // 2-cycle glitch
    line = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 line = 1'b0;
    idle(1);
    chk("glitch_busy", 32'(bsy), 32'd1);
    idle(20);
    chk("glitch_idle", 32'(bsy), 32'd0);
    chk("glitch_valid", 32'(vld), 32'd0);
    chk("glitch_flags", 32'(perr_cnt0 + ferr_cnt0), 32'd0);

    // Even parity instance
    sel = 1'b1;
    idle(4);
    send_frame(8'h03, 1);
    idle(6);
    chk("par_bad_perr", 32'(perr_cnt1), 32'd1);
    chk("par_bad_valid", 32'(vld), 32'd0);
    fork
      send_frame(8'h03, 0);
      wait_valid(lat);
    join
    chk("par_ok_latency", 32'(lat), 32'd88);
    chk("par_ok_dout", 32'(dout), 32'h03);
    idle(6);
    chk("par_ok_perr", 32'(perr_cnt1 + ferr_cnt1), 32'd1);
    sel = 1'b0;
    idle(4);

    // Stuck-high line
    line = 1'b1;
    idle(400);
    chk("stuck_ferr", 32'(ferr_cnt0), 32'd1);
    chk("stuck_busy", 32'(bsy), 32'd1);
    chk("stuck_valid", 32'(vld), 32'd0);
    line = 1'b0;
    idle(6);
    chk("stuck_release", 32'(bsy), 32'd0);
    fork
      send_frame(8'h5A, -1);
      wait_valid(lat);
    join
    chk("after_stuck_latency", 32'(lat), 32'd80);
    chk("after_stuck_dout", 32'(dout), 32'h5A);
    idle(6);

    // Overrun with consumer stalled
    ready = 1'b0;
    send_frame(8'h11, -1);
    idle(4);
    chk("ovr_first_valid", 32'(vld), 32'd1);
    chk("ovr_first_dout", 32'(dout), 32'h11);
    send_frame(8'h22, -1);
    idle(4);
    chk("ovr_count", 32'(ovr_cnt0), 32'd1);
    chk("ovr_held_dout", 32'(dout), 32'h11);
    chk("ovr_held_valid", 32'(vld), 32'd1);
    ready = 1'b1;
    idle(1);
    chk("accept_valid", 32'(vld), 32'd0);
    chk("accept_dout", 32'(dout), 32'h11);
    idle(4);

    // Reset during data bit 4, with a word held
    ready = 1'b0;
    send_frame(8'h77, -1);
    idle(4);
    chk("pre_rst_valid", 32'(vld), 32'd1);
    ready = 1'b1;
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    line = 1'b1;
    idle(4);
    ready = 1'b0;
    reset = 1'b1;
    line  = 1'b0;
    idle(3);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(bsy), 32'd0);
    reset = 1'b0;
    ready = 1'b1;
    idle(100);
    chk("midrst_no_out", 32'(vld), 32'd0);
    chk("midrst_no_err", 32'(perr_cnt0 + ferr_cnt0 + ovr_cnt0), 32'd2);
    fork
      send_frame(8'h3C, -1);
      wait_valid(lat);
    join
    chk("post_rst_latency", 32'(lat), 32'd80);
    chk("post_rst_dout", 32'(dout), 32'h3C);
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
